// File: rtl/ahb_lite_subsystem.sv
// AHB-Lite subsystem: a command-driven bus master with burst address generation
// and a word-addressed SRAM slave with byte lanes, ERROR responses and wait states.
module ahb_lite_subsystem #(
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] i_HADDR,
   input  logic [31:0] i_HWDATA,
   input  logic        i_HWRITE,
   input  logic [1:0]  i_HTRANS,
   input  logic [2:0]  i_HSIZE,
   input  logic [2:0]  i_HBURST,
   output logic [31:0] o_HRDATA,
   output logic        o_HREADY,
   output logic        o_HRESP
);

   localparam int unsigned AW       = $clog2(MEM_DEPTH);
   localparam logic [31:0] MemBytes = 32'(MEM_DEPTH * 4);

   typedef enum logic [1:0] {TrIdle, TrBusy, TrNonseq, TrSeq} htrans_e;

   // Address phase (bus) registers
   htrans_e     htrans_q, htrans_d;
   logic [31:0] haddr_q, haddr_d;
   logic        hwrite_q, hwrite_d;
   logic [2:0]  hsize_q, hsize_d;
   logic [2:0]  hburst_q, hburst_d;
   logic [31:0] cmd_wdata_q, cmd_wdata_d;
   logic        burst_active_q, burst_active_d;
   logic [4:0]  beat_cnt_q, beat_cnt_d;

   // Data phase registers
   logic          dp_valid_q, dp_write_q, dp_err_q, err_second_q;
   logic [AW+1:0] dp_addr_q;
   logic [1:0]    dp_size_q;
   logic [31:0]   hwdata_q;
   logic [7:0]    wait_cnt_q;

   logic [31:0] mem_q [MEM_DEPTH];

   logic          hready, err_done, addr_err, mem_we, start;
   logic [31:0]   size_bytes, wrap_mask, seq_addr, nonseq_mask;
   logic [4:0]    beats;
   logic          fixed, wrap;
   logic [3:0]    byte_en;
   logic [AW-1:0] dp_idx;

   always_comb begin
      hready = 1'b1;
      if (dp_valid_q) begin
         hready = dp_err_q ? err_second_q : (wait_cnt_q == 8'(WAIT_STATES));
      end
   end

   assign err_done = dp_valid_q & dp_err_q & err_second_q;
   assign addr_err = (haddr_q >= MemBytes) || (hsize_q > 3'd2);
   assign dp_idx   = dp_addr_q[AW+1:2];
   assign mem_we   = hready & dp_valid_q & ~dp_err_q & dp_write_q;

   // SEQ address from the burst control latched at NONSEQ
   always_comb begin
      size_bytes = 32'd1 << hsize_q;
      case (hburst_q[2:1])
         2'b01:   beats = 5'd4;
         2'b10:   beats = 5'd8;
         2'b11:   beats = 5'd16;
         default: beats = 5'd0;
      endcase
      fixed     = (hburst_q[2:1] != 2'b00);
      wrap      = fixed & ~hburst_q[0];
      wrap_mask = ({27'd0, beats} * size_bytes) - 32'd1;
      seq_addr  = haddr_q + size_bytes;
      if (wrap) begin
         seq_addr = (haddr_q & ~wrap_mask) | ((haddr_q + size_bytes) & wrap_mask);
      end
   end

   always_comb begin
      htrans_d       = htrans_q;
      haddr_d        = haddr_q;
      hwrite_d       = hwrite_q;
      hsize_d        = hsize_q;
      hburst_d       = hburst_q;
      cmd_wdata_d    = cmd_wdata_q;
      burst_active_d = burst_active_q;
      beat_cnt_d     = beat_cnt_q;
      start          = 1'b0;
      nonseq_mask    = (32'd1 << i_HSIZE) - 32'd1;
      if (hready) begin
         if (err_done) begin
            // An ERROR cancels the rest of the burst
            htrans_d       = TrIdle;
            burst_active_d = 1'b0;
         end else begin
            hwrite_d    = i_HWRITE;
            cmd_wdata_d = i_HWDATA;
            unique case (htrans_e'(i_HTRANS))
               TrIdle: begin
                  htrans_d       = TrIdle;
                  burst_active_d = 1'b0;
               end
               TrBusy:   htrans_d = burst_active_q ? TrBusy : TrIdle;
               TrNonseq: start = 1'b1;
               TrSeq: begin
                  if (!burst_active_q) begin
                     start = 1'b1;
                  end else if (fixed && (beat_cnt_q == beats)) begin
                     // Fixed burst already complete: stay quiet until IDLE/NONSEQ
                     htrans_d = TrIdle;
                  end else begin
                     htrans_d = TrSeq;
                     haddr_d  = seq_addr;
                     if (fixed) beat_cnt_d = beat_cnt_q + 5'd1;
                  end
               end
            endcase
            if (start) begin
               htrans_d       = TrNonseq;
               haddr_d        = i_HADDR & ~nonseq_mask;
               hsize_d        = i_HSIZE;
               hburst_d       = i_HBURST;
               burst_active_d = (i_HBURST != 3'd0);
               beat_cnt_d     = 5'd1;
            end
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         htrans_q       <= TrIdle;
         haddr_q        <= '0;
         hwrite_q       <= 1'b0;
         hsize_q        <= '0;
         hburst_q       <= '0;
         cmd_wdata_q    <= '0;
         burst_active_q <= 1'b0;
         beat_cnt_q     <= '0;
      end else begin
         htrans_q       <= htrans_d;
         haddr_q        <= haddr_d;
         hwrite_q       <= hwrite_d;
         hsize_q        <= hsize_d;
         hburst_q       <= hburst_d;
         cmd_wdata_q    <= cmd_wdata_d;
         burst_active_q <= burst_active_d;
         beat_cnt_q     <= beat_cnt_d;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         dp_valid_q   <= 1'b0;
         dp_write_q   <= 1'b0;
         dp_err_q     <= 1'b0;
         err_second_q <= 1'b0;
         dp_addr_q    <= '0;
         dp_size_q    <= '0;
         hwdata_q     <= '0;
         wait_cnt_q   <= '0;
      end else if (hready) begin
         dp_valid_q   <= (htrans_q == TrNonseq) || (htrans_q == TrSeq);
         dp_write_q   <= hwrite_q;
         dp_err_q     <= addr_err;
         err_second_q <= 1'b0;
         dp_addr_q    <= haddr_q[AW+1:0];
         dp_size_q    <= hsize_q[1:0];
         hwdata_q     <= cmd_wdata_q;
         wait_cnt_q   <= '0;
      end else if (dp_err_q) begin
         err_second_q <= 1'b1;
      end else begin
         wait_cnt_q <= wait_cnt_q + 8'd1;
      end
   end

   always_comb begin
      case (dp_size_q)
         2'b00:   byte_en = 4'b0001 << dp_addr_q[1:0];
         2'b01:   byte_en = dp_addr_q[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem_q[dp_idx][8*b +: 8] <= hwdata_q[8*b +: 8];
         end
      end
   end

   assign o_HREADY = hready;
   assign o_HRESP  = dp_valid_q & dp_err_q;
   assign o_HRDATA = (dp_valid_q & ~dp_err_q & ~dp_write_q) ? mem_q[dp_idx] : '0;

endmodule

// File: tb/tb_ahb_lite_subsystem.sv
// Bench for ahb_lite_subsystem: command table plus hand-built corner sequences,
// read data checked through a scoreboard queue against per-command expectations.
module tb_ahb_lite_subsystem;

   localparam int KN = 0;  // no transfer
   localparam int KW = 1;  // OKAY write
   localparam int KR = 2;  // OKAY read, compare data
   localparam int KE = 3;  // ERROR response

   localparam logic [1:0] ID = 2'b00, BY = 2'b01, NS = 2'b10, SQ = 2'b11;
   localparam logic [2:0] SZB = 3'b000, SZH = 3'b001, SZW = 3'b010;
   localparam logic [2:0] SGL = 3'd0, INC = 3'd1, WR4 = 3'd2, IN4 = 3'd3;

   typedef struct {
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          kind;
      logic [31:0] exp;
   } vec_t;

   logic        HCLK, HRESETn;
   logic [31:0] i_HADDR, i_HWDATA;
   logic        i_HWRITE;
   logic [1:0]  i_HTRANS;
   logic [2:0]  i_HSIZE, i_HBURST;
   logic [31:0] o_HRDATA;
   logic        o_HREADY, o_HRESP;

   ahb_lite_subsystem #(
      .MEM_DEPTH  (256),
      .WAIT_STATES(0)
   ) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .i_HADDR (i_HADDR),
      .i_HWDATA(i_HWDATA),
      .i_HWRITE(i_HWRITE),
      .i_HTRANS(i_HTRANS),
      .i_HSIZE (i_HSIZE),
      .i_HBURST(i_HBURST),
      .o_HRDATA(o_HRDATA),
      .o_HREADY(o_HREADY),
      .o_HRESP (o_HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int          n_checks = 0;
   int          n_fail = 0;
   int          addr_kind = KN;
   int          data_kind = KN;
   bit          err_second = 1'b0;
   logic [31:0] exp_q[$];
   vec_t        tbl[$];

   function automatic vec_t cmd(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                                input logic [2:0] bu, input logic [31:0] a,
                                input logic [31:0] d, input int k, input logic [31:0] e);
      vec_t v;
      v.trans = tr; v.wr = wr; v.size = sz; v.burst = bu;
      v.addr = a; v.wdata = d; v.kind = k; v.exp = e;
      return v;
   endfunction

   function automatic vec_t idle();
      return cmd(ID, 1'b0, SZW, SGL, 32'h0, 32'h0, KN, 32'h0);
   endfunction

   function automatic vec_t rd(input logic [31:0] a, input logic [31:0] e);
      return cmd(NS, 1'b0, SZW, SGL, a, 32'h0, KR, e);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   // Present one command; hold it until an edge with HREADY=1 accepts it.
   task automatic step(input vec_t v);
      bit          done;
      logic        rdy;
      logic [31:0] e;
      done = 1'b0;
      @(negedge HCLK);
      i_HTRANS = v.trans; i_HWRITE = v.wr; i_HSIZE = v.size;
      i_HBURST = v.burst; i_HADDR = v.addr; i_HWDATA = v.wdata;
      for (int t = 0; t < 8 && !done; t++) begin
         if (t > 0) @(negedge HCLK);
         rdy = o_HREADY;
         check("hready", {31'd0, rdy}, {31'd0, !(data_kind == KE && !err_second)});
         check("hresp", {31'd0, o_HRESP}, {31'd0, data_kind == KE});
         if (data_kind == KR) begin
            if (rdy) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL scoreboard: read data phase with no expected value");
               end else begin
                  e = exp_q.pop_front();
                  check("hrdata", o_HRDATA, e);
               end
            end
         end else begin
            check("hrdata_default", o_HRDATA, 32'h0);
         end
         @(posedge HCLK);
         if (rdy) begin
            done       = 1'b1;
            data_kind  = addr_kind;
            addr_kind  = v.kind;
            err_second = 1'b0;
            if (v.kind == KR) exp_q.push_back(v.exp);
         end else begin
            err_second = 1'b1;
         end
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL hready_timeout: command not accepted within 8 cycles");
      end
   endtask

   task automatic pulse_reset();
      @(negedge HCLK);
      HRESETn = 1'b0;
      @(posedge HCLK);
      @(negedge HCLK);
      check("rst_hready", {31'd0, o_HREADY}, 32'd1);
      check("rst_hresp", {31'd0, o_HRESP}, 32'd0);
      check("rst_hrdata", o_HRDATA, 32'h0);
      HRESETn  = 1'b1;
      i_HTRANS = ID;
      addr_kind = KN; data_kind = KN; err_second = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESETn = 1'b0;
      i_HTRANS = ID; i_HWRITE = 1'b0; i_HSIZE = SZW; i_HBURST = SGL;
      i_HADDR = '0; i_HWDATA = '0;
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      check("init_hready", {31'd0, o_HREADY}, 32'd1);
      check("init_hresp", {31'd0, o_HRESP}, 32'd0);
      check("init_hrdata", o_HRDATA, 32'h0);
      HRESETn = 1'b1;

      // Write then read back
      tbl.push_back(cmd(NS, 1'b1, SZW, SGL, 32'h24, 32'h10101010, KW, 0));
      tbl.push_back(cmd(NS, 1'b1, SZW, SGL, 32'h28, 32'h20202020, KW, 0));
      tbl.push_back(rd(32'h24, 32'h10101010));
      tbl.push_back(rd(32'h28, 32'h20202020));
      // INCR write burst from unaligned 0x32, then INCR read back
      for (int i = 0; i < 11; i++)
         tbl.push_back(cmd(i == 0 ? NS : SQ, 1'b1, SZW, INC, i == 0 ? 32'h32 : 32'h0,
                           32'h30303030 + 32'(16 * i), KW, 0));
      for (int i = 0; i < 11; i++)
         tbl.push_back(cmd(i == 0 ? NS : SQ, 1'b0, SZW, INC, i == 0 ? 32'h32 : 32'h0,
                           32'h0, KR, 32'h30303030 + 32'(16 * i)));
      tbl.push_back(idle());
      // WRAP4 from 0xFF: 0xFC,0xF0,0xF4,0xF8 then excess SEQs become IDLE
      for (int i = 0; i < 11; i++)
         tbl.push_back(cmd(i == 0 ? NS : SQ, 1'b1, SZW, WR4, i == 0 ? 32'hFF : 32'h100,
                           32'h11111212 + 32'(i), i < 4 ? KW : KN, 0));
      tbl.push_back(idle());
      tbl.push_back(rd(32'hFC, 32'h11111212));
      tbl.push_back(rd(32'hF0, 32'h11111213));
      tbl.push_back(rd(32'hF4, 32'h11111214));
      tbl.push_back(rd(32'hF8, 32'h11111215));
      tbl.push_back(rd(32'h100, 32'h0));
      tbl.push_back(rd(32'hEC, 32'h0));
      // Byte and halfword lanes, read immediately after write
      tbl.push_back(cmd(NS, 1'b1, SZB, SGL, 32'h25, 32'hABABABAB, KW, 0));
      tbl.push_back(rd(32'h24, 32'h1010AB10));
      tbl.push_back(cmd(NS, 1'b1, SZH, SGL, 32'h2A, 32'hCDEFCDEF, KW, 0));
      tbl.push_back(rd(32'h28, 32'hCDEF2020));
      // SEQ with no burst in progress starts from i_HADDR
      tbl.push_back(cmd(SQ, 1'b1, SZW, INC, 32'h40, 32'h44444444, KW, 0));
      tbl.push_back(rd(32'h40, 32'h44444444));
      foreach (tbl[i]) step(tbl[i]);
      step(idle());

      // ERROR on out-of-range address; the command taken at the end of it is dropped
      step(cmd(NS, 1'b1, SZW, SGL, 32'h400, 32'hEEEEEEEE, KE, 0));
      step(idle());
      step(cmd(NS, 1'b1, SZW, SGL, 32'h24, 32'hDEADBEEF, KN, 0));
      step(rd(32'h0, 32'h0));
      step(rd(32'h24, 32'h1010AB10));
      // ERROR on unsupported size
      step(cmd(NS, 1'b1, 3'b011, SGL, 32'h24, 32'h55555555, KE, 0));
      step(idle());
      step(idle());
      step(rd(32'h24, 32'h1010AB10));

      // BUSY inside INCR: no extra transfer, no skipped address
      step(cmd(NS, 1'b1, SZW, INC, 32'h80, 32'hA0A0A0A0, KW, 0));
      step(cmd(SQ, 1'b1, SZW, INC, 32'h0, 32'hA1A1A1A1, KW, 0));
      step(cmd(BY, 1'b1, SZW, INC, 32'h999, 32'hFFFFFFFF, KN, 0));
      step(cmd(SQ, 1'b1, SZW, INC, 32'h0, 32'hA2A2A2A2, KW, 0));
      step(cmd(SQ, 1'b1, SZW, INC, 32'h0, 32'hA3A3A3A3, KW, 0));
      step(idle());
      step(cmd(NS, 1'b0, SZW, INC, 32'h80, 32'h0, KR, 32'hA0A0A0A0));
      step(cmd(SQ, 1'b0, SZW, INC, 32'h0, 32'h0, KR, 32'hA1A1A1A1));
      step(cmd(SQ, 1'b0, SZW, INC, 32'h0, 32'h0, KR, 32'hA2A2A2A2));
      step(cmd(SQ, 1'b0, SZW, INC, 32'h0, 32'h0, KR, 32'hA3A3A3A3));
      step(rd(32'h90, 32'h0));
      // BUSY inside INCR4 does not consume a beat; fifth SEQ is suppressed
      step(cmd(NS, 1'b1, SZW, IN4, 32'hA0, 32'hB0B0B0B0, KW, 0));
      step(cmd(SQ, 1'b1, SZW, IN4, 32'h0, 32'hB1B1B1B1, KW, 0));
      step(cmd(BY, 1'b1, SZW, IN4, 32'h0, 32'hFFFFFFFF, KN, 0));
      step(cmd(SQ, 1'b1, SZW, IN4, 32'h0, 32'hB2B2B2B2, KW, 0));
      step(cmd(SQ, 1'b1, SZW, IN4, 32'h0, 32'hB3B3B3B3, KW, 0));
      step(cmd(SQ, 1'b1, SZW, IN4, 32'hC0, 32'hB4B4B4B4, KN, 0));
      step(idle());
      step(rd(32'hA8, 32'hB2B2B2B2));
      step(rd(32'hAC, 32'hB3B3B3B3));
      step(rd(32'hB0, 32'h0));
      step(rd(32'hC0, 32'h0));

      // Reset mid-burst clears memory and bus state
      step(cmd(NS, 1'b1, SZW, INC, 32'h60, 32'h66666666, KW, 0));
      step(cmd(SQ, 1'b1, SZW, INC, 32'h0, 32'h66666667, KW, 0));
      pulse_reset();
      step(cmd(SQ, 1'b1, SZW, INC, 32'h70, 32'h77777777, KW, 0));
      step(rd(32'h24, 32'h0));
      step(rd(32'h60, 32'h0));
      step(rd(32'h64, 32'h0));
      step(rd(32'h70, 32'h77777777));
      step(idle());
      step(idle());
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
